// File: rtl/itype_instr_sequencer_if.sv
// Instruction stream handshake between the sequencer and the imem response
// path: a plain valid/ready channel carrying one 32-bit instruction word.
interface itype_instr_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/itype_instr_sequencer.sv
// Instruction sequencer for the lockstep harness: warm-up NOPs, a burst of
// pseudo-random legal OP-IMM instructions driven by a Galois LFSR, then drain
// NOPs. The valid/ready channel is driven purely from registered state, so
// instr_ready never reaches instr_valid combinationally.
module itype_instr_sequencer #(
  parameter logic [31:0] LFSR_SEED   = 32'h000117E4,
  parameter int          NUM_INSTRS  = 100,
  parameter int          WARMUP_NOPS = 2,
  parameter int          DRAIN_NOPS  = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  itype_instr_sequencer_if.master        bus,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    issued_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'd0) ? 32'h00000001 : LFSR_SEED;

  // Last counter value of each phase (only used when that phase is non-empty).
  localparam logic [15:0] WARM_LAST  = 16'(WARMUP_NOPS - 1);
  localparam logic [15:0] RUN_LAST   = 16'(NUM_INSTRS - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_NOPS - 1);

  // Empty phases are skipped entirely when choosing where to go next.
  localparam state_t AFTER_RUN  = (DRAIN_NOPS  != 0) ? S_DRAIN  : S_DONE;
  localparam state_t AFTER_WARM = (NUM_INSTRS  != 0) ? S_RUN    : AFTER_RUN;
  localparam state_t ON_START   = (WARMUP_NOPS != 0) ? S_WARMUP : AFTER_WARM;

  state_t      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] issued_q, issued_d;
  logic        valid;
  logic        xfer;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  // Shift-immediate encodings only allow shamt[4:0] plus the SRAI bit (imm[10]).
  function automatic logic [31:0] encode_itype(input logic [31:0] s);
    logic [11:0] imm;
    logic [2:0]  f3;
    imm = s[31:20];
    f3  = s[14:12];
    if (f3 == 3'd1)      imm = imm & 12'h01F;
    else if (f3 == 3'd5) imm = imm & 12'h41F;
    return {imm, s[19:15], f3, s[11:7], 7'b0010011};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  assign valid = (state_q == S_WARMUP) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign xfer  = valid && bus.instr_ready;

  assign bus.instr_valid = valid;
  assign bus.instr       = (state_q == S_RUN) ? encode_itype(lfsr_q) : NOP;
  assign busy            = valid;
  assign done            = (state_q == S_DONE);
  assign issued_count    = issued_q;

  // Next-state: phase counter advances only on transfers; the final transfer
  // of a phase switches state and clears the counter on the same edge.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = ON_START;
          lfsr_d   = SEED_EFF;
          cnt_d    = 16'd0;
          issued_d = 16'd0;
        end
      end
      S_WARMUP: begin
        if (xfer) begin
          if (cnt_q == WARM_LAST) begin
            state_d = AFTER_WARM;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          issued_d = sat_inc(issued_q);
          lfsr_d   = lfsr_next(lfsr_q);
          if (cnt_q == RUN_LAST) begin
            state_d = AFTER_RUN;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        if (xfer) begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = S_DONE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any run on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_EFF;
      cnt_q    <= 16'd0;
      issued_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
    end
  end

endmodule

// File: tb/tb_itype_instr_sequencer.sv
// Scoreboard bench for itype_instr_sequencer: expected words are queued when
// a run is started; per-instance monitors pop and compare on every transfer.
module tb_itype_instr_sequencer;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] SEED   = 32'h000117E4;
  localparam logic [31:0] WORD0  = 32'h00011793;  // slli x15,x2,0
  localparam logic [31:0] WORD1  = 32'h00008B93;  // addi x23,x1,0 (lfsr 0x00008BF2)

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic [15:0] cnt0, cnt1, cnt2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int xf0 = 0, xf1 = 0, xf2 = 0;
  int last0 = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] gen_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  itype_instr_sequencer_if if0();
  itype_instr_sequencer_if if1();
  itype_instr_sequencer_if if2();

  itype_instr_sequencer u0 (
    .clk(clk), .reset(rst), .start(start0), .bus(if0),
    .busy(busy0), .done(done0), .issued_count(cnt0)
  );

  itype_instr_sequencer #(.NUM_INSTRS(10000)) u1 (
    .clk(clk), .reset(rst), .start(start1), .bus(if1),
    .busy(busy1), .done(done1), .issued_count(cnt1)
  );

  itype_instr_sequencer #(.WARMUP_NOPS(0), .DRAIN_NOPS(0), .NUM_INSTRS(1)) u2 (
    .clk(clk), .reset(rst), .start(start2), .bus(if2),
    .busy(busy2), .done(done2), .issued_count(cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference stream: first two random words are hand-derived constants,
  // the rest come from an independent LFSR/encoder model.
  task automatic gen_run(input int warm, input int n, input int drain);
    logic [31:0] s;
    logic [31:0] hi;
    logic [2:0]  f3;
    logic [11:0] imm;
    gen_q.delete();
    for (int i = 0; i < warm; i++) gen_q.push_back(NOP);
    s = SEED;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        gen_q.push_back(WORD0);
      end else if (i == 1) begin
        gen_q.push_back(WORD1);
      end else begin
        f3  = s[14:12];
        imm = s[31:20];
        if (f3 == 3'd1) imm = {7'd0, imm[4:0]};
        if (f3 == 3'd5) imm = {1'b0, imm[10], 5'd0, imm[4:0]};
        hi = {imm, 20'd0} | {12'd0, s[19:15], 15'd0} | {17'd0, f3, 12'd0}
           | {20'd0, s[11:7], 7'd0} | 32'h13;
        gen_q.push_back(hi);
      end
      s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    end
    for (int i = 0; i < drain; i++) gen_q.push_back(NOP);
  endtask

  // Monitors: sample half a cycle before the edge that commits the transfer.
  always @(negedge clk) begin
    if (!rst && if0.instr_valid && if0.instr_ready) begin
      xf0++;
      last0 = cyc;
      if (q0.size() == 0) chk("u0_unexpected_xfer", if0.instr, 32'hxxxxxxxx);
      else chk("u0_word", if0.instr, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [6:0] hi7;
    if (!rst && if1.instr_valid && if1.instr_ready) begin
      xf1++;
      hi7 = if1.instr[31:25];
      if (q1.size() == 0) chk("u1_unexpected_xfer", if1.instr, 32'hxxxxxxxx);
      else chk("u1_word", if1.instr, q1.pop_front());
      if (if1.instr[14:12] == 3'd1) chk("u1_slli_imm_hi", {25'd0, hi7}, 32'd0);
      if (if1.instr[14:12] == 3'd5)
        chk("u1_sr_imm_hi_legal", {31'd0, (hi7 == 7'd0) || (hi7 == 7'h20)}, 32'd1);
    end
  end

  always @(negedge clk) begin
    if (!rst && if2.instr_valid && if2.instr_ready) begin
      xf2++;
      if (q2.size() == 0) chk("u2_unexpected_xfer", if2.instr, 32'hxxxxxxxx);
      else chk("u2_word", if2.instr, q2.pop_front());
    end
  end

  initial begin
    int base;
    int guard;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    if0.instr_ready = 1'b0; if1.instr_ready = 1'b0; if2.instr_ready = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_valid", {31'd0, if0.instr_valid}, 32'd0);
    chk("rst_instr", if0.instr, NOP);
    chk("rst_busy",  {31'd0, busy0}, 32'd0);
    chk("rst_done",  {31'd0, done0}, 32'd0);
    chk("rst_count", {16'd0, cnt0}, 32'd0);
    rst = 1'b0;
    step();

    // Full run, ready held high
    gen_run(2, 100, 3);
    foreach (gen_q[i]) q0.push_back(gen_q[i]);
    base = xf0;
    if0.instr_ready = 1'b1;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    guard = 0;
    while (!done0 && guard < 400) begin step(); guard++; end
    chk("A_done",        {31'd0, done0}, 32'd1);
    chk("A_xfers",       xf0 - base, 32'd105);
    chk("A_done_timing", cyc, last0 + 1);
    chk("A_count",       {16'd0, cnt0}, 32'd100);
    chk("A_busy",        {31'd0, busy0}, 32'd0);
    chk("A_valid",       {31'd0, if0.instr_valid}, 32'd0);
    chk("A_queue_empty", q0.size(), 32'd0);

    // Stall during RUN: ready 1,0,0,1
    gen_run(2, 100, 3);
    foreach (gen_q[i]) q0.push_back(gen_q[i]);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    chk("B_first_word", if0.instr, WORD0);
    chk("B_count0", {16'd0, cnt0}, 32'd0);
    step();
    chk("B_count1", {16'd0, cnt0}, 32'd1);
    chk("B_word1",  if0.instr, WORD1);
    if0.instr_ready = 1'b0;
    step();
    chk("B_stall1_word",  if0.instr, WORD1);
    chk("B_stall1_count", {16'd0, cnt0}, 32'd1);
    step();
    chk("B_stall2_word",  if0.instr, WORD1);
    chk("B_stall2_count", {16'd0, cnt0}, 32'd1);
    chk("B_stall2_valid", {31'd0, if0.instr_valid}, 32'd1);
    if0.instr_ready = 1'b1;
    step();
    chk("B_count2", {16'd0, cnt0}, 32'd2);
    guard = 0;
    while (!done0 && guard < 400) begin step(); guard++; end
    chk("B_done",  {31'd0, done0}, 32'd1);
    chk("B_count", {16'd0, cnt0}, 32'd100);

    // Reset on the 50th RUN transfer, then restart
    gen_run(2, 100, 3);
    foreach (gen_q[i]) q0.push_back(gen_q[i]);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    guard = 0;
    while (cnt0 != 16'd49 && guard < 400) begin step(); guard++; end
    chk("C_reached_49", {16'd0, cnt0}, 32'd49);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q0.delete();
    chk("C_valid", {31'd0, if0.instr_valid}, 32'd0);
    chk("C_count", {16'd0, cnt0}, 32'd0);
    chk("C_busy",  {31'd0, busy0}, 32'd0);
    chk("C_done",  {31'd0, done0}, 32'd0);
    chk("C_instr", if0.instr, NOP);
    gen_run(2, 100, 3);
    foreach (gen_q[i]) q0.push_back(gen_q[i]);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    chk("C_restart_word", if0.instr, WORD0);
    guard = 0;
    while (!done0 && guard < 400) begin step(); guard++; end
    chk("C_done",        {31'd0, done0}, 32'd1);
    chk("C_queue_empty", q0.size(), 32'd0);

    // Long run with random ready: stream match and shift-immediate legality
    gen_run(2, 10000, 3);
    foreach (gen_q[i]) q1.push_back(gen_q[i]);
    if1.instr_ready = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    guard = 0;
    while (!done1 && guard < 40000) begin
      if1.instr_ready = ($urandom_range(0, 3) != 0);
      step();
      guard++;
    end
    chk("D_done",        {31'd0, done1}, 32'd1);
    chk("D_count",       {16'd0, cnt1}, 32'd10000);
    chk("D_xfers",       xf1, 32'd10005);
    chk("D_queue_empty", q1.size(), 32'd0);

    // No warm-up/drain, single instruction, start while busy ignored
    gen_run(0, 1, 0);
    foreach (gen_q[i]) q2.push_back(gen_q[i]);
    if2.instr_ready = 1'b0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("E_busy",  {31'd0, busy2}, 32'd1);
    chk("E_word",  if2.instr, WORD0);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("E_ignored_start_busy",  {31'd0, busy2}, 32'd1);
    chk("E_ignored_start_word",  if2.instr, WORD0);
    chk("E_ignored_start_count", {16'd0, cnt2}, 32'd0);
    if2.instr_ready = 1'b1;
    step();
    chk("E_done",  {31'd0, done2}, 32'd1);
    chk("E_count", {16'd0, cnt2}, 32'd1);
    chk("E_valid", {31'd0, if2.instr_valid}, 32'd0);
    step();
    step();
    chk("E_xfers", xf2, 32'd1);
    chk("E_queue_empty", q2.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/itype_instr_sequencer.md
Name: itype_instr_sequencer

Overview:
Sequences the instruction stream fed into the sodor3 lockstep verification harness (core plus architectural model). Produces a programmable-length burst of pseudo-random, legal RISC-V OP-IMM instructions, framed by leading warm-up NOPs and trailing drain NOPs. Uses a valid/ready handshake toward the imem response path. Reports completion so the harness can stop the run and compare register files.

Parameters:
LFSR_SEED, 32'h000117E4, initial LFSR state; a value of 0 is replaced by 32'h00000001
NUM_INSTRS, 100, random instructions issued per run (1..2^16-1)
WARMUP_NOPS, 2, NOPs issued before the random burst (0..255)
DRAIN_NOPS, 3, NOPs issued after the burst to flush the 3-stage pipe (0..255)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse; begins a run when in IDLE or DONE, ignored otherwise
instr_ready  input  1  consumer accepts instr this cycle
instr_valid  output  1  instr is valid
instr  output  32  instruction word
busy  output  1  high in WARMUP, RUN and DRAIN
done  output  1  high in DONE until next start or reset
issued_count  output  16  random (non-NOP) instructions accepted in current run

Behaviour:
- Reset (synchronous, active-high): state=IDLE; lfsr=LFSR_SEED (or 1 if seed is 0); instr_valid=0; instr=32'h00000013; busy=0; done=0; issued_count=0; phase counter=0. A reset asserted mid-run aborts the run in the same edge; no partial outputs persist.
- States: IDLE, WARMUP, RUN, DRAIN, DONE.
- IDLE/DONE + start: go to WARMUP (or RUN if WARMUP_NOPS=0; or DRAIN if NUM_INSTRS=0, treated as 0 random). Clear issued_count and done; reload lfsr from seed; clear phase counter.
- A "transfer" is instr_valid && instr_ready on a rising edge. The phase counter advances only on a transfer.
- WARMUP: instr_valid=1, instr=32'h00000013. After WARMUP_NOPS transfers, go to RUN.
- RUN: instr_valid=1, instr built combinationally from the current lfsr:
  - imm=lfsr[31:20], rs1=lfsr[19:15], funct3=lfsr[14:12], rd=lfsr[11:7].
  - funct3==1 (SLLI): imm &= 12'h01F. funct3==5 (SRLI/SRAI): imm &= 12'h41F. Other funct3 values: imm unmasked.
  - instr = {imm, rs1, funct3, rd, 7'b0010011}.
  - On each transfer: issued_count+1, and lfsr advances one step (Galois, right shift, xor mask 32'h80200003 when lsb=1).
  - After NUM_INSTRS transfers, go to DRAIN (or DONE if DRAIN_NOPS=0).
- DRAIN: NOP words exactly as in WARMUP. After DRAIN_NOPS transfers, go to DONE.
- DONE: instr_valid=0, instr=NOP, done=1.
- Handshake rules: while instr_valid=1 and instr_ready=0, instr and lfsr hold stable. instr_valid never drops between transfers within busy states. There is no combinational path from instr_ready to instr_valid.
- start while busy is ignored.
- issued_count saturates at 16'hFFFF.
- Phase boundary transfer: the state change and the counter reset happen on the same edge as the final transfer of a phase, so there is no bubble between phases when instr_ready stays high.

Test Plan:
- Seed 32'h000117E4, default parameters, ready held high, start at cycle 1 → two NOPs 32'h00000013, then first random word 32'h00011793 (slli x15,x2,0), then lfsr=32'h00008BF2.
- Ready held high, NUM_INSTRS=100 → exactly 2+100+3=105 transfers, done rises on the cycle after the last transfer, issued_count=100, busy=0.
- Ready toggled 1,0,0,1 during RUN → instr unchanged across the stall cycles, issued_count increments only on the two ready-high edges.
- Randomized run of 10k instructions → every funct3=1 word has imm[11:5]=0, and every funct3=5 word has imm[11:5] in {0, 7'b0100000}.
- Reset asserted at the 50th RUN transfer → next cycle shows IDLE outputs (valid=0, count=0); a following start reproduces the same first word 32'h00011793.
- WARMUP_NOPS=0, DRAIN_NOPS=0, NUM_INSTRS=1 → a single random transfer, then DONE; start pulsed while busy has no effect.
